// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit, one bit per cycle.
// Divide-by-zero and signed overflow complete on a two-cycle fast path.
module muldiv_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  kill,
    input  logic [DATA_WIDTH-1:0] op1,
    input  logic [DATA_WIDTH-1:0] op2,
    input  logic [2:0]            MDctrl,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] result
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t         state, state_nx;
    logic [2:0]     op_q;
    logic           s1_q, s2_q, fast_q;
    logic [W-1:0]   b_q;
    logic [2*W-1:0] acc_q;
    logic [CW-1:0]  cnt_q;

    logic           is_div, sg1, sg2, neg1, neg2;
    logic           div0, ovf, fast, accept;
    logic [W-1:0]   m1, m2, fast_val;

    always_comb begin
        is_div   = MDctrl[2];
        sg1      = is_div ? ~MDctrl[0] : (MDctrl[1] ^ MDctrl[0]);
        sg2      = is_div ? ~MDctrl[0] : (MDctrl[1:0] == 2'b01);
        neg1     = sg1 & op1[W-1];
        neg2     = sg2 & op2[W-1];
        m1       = neg1 ? -op1 : op1;
        m2       = neg2 ? -op2 : op2;
        div0     = is_div && (op2 == '0);
        ovf      = is_div && !MDctrl[0]
                   && (op1 == {1'b1, {(W-1){1'b0}}})
                   && (op2 == '1);
        fast     = div0 | ovf;
        // REM keeps the dividend on /0 and is zero on overflow
        fast_val = MDctrl[1] ? (div0 ? op1 : '0)
                             : (div0 ? '1 : op1);
    end

    assign accept = (state == IDLE) && start && !kill;
    assign busy   = (state != IDLE);

    logic [W:0]     mul_sum, div_sh;
    logic [W-1:0]   div_df;
    logic           div_ge;
    logic [2*W-1:0] mul_nx, div_nx, prod_s;
    logic [W-1:0]   q_s, r_s, sel;

    always_comb begin
        mul_sum = {1'b0, acc_q[2*W-1:W]} + {1'b0, b_q};
        mul_nx  = acc_q[0] ? {mul_sum, acc_q[W-1:1]}
                           : {1'b0, acc_q[2*W-1:1]};
        div_sh  = {acc_q[2*W-1:W], acc_q[W-1]};
        div_ge  = div_sh >= {1'b0, b_q};
        div_df  = div_sh[W-1:0] - b_q;
        div_nx  = div_ge ? {div_df, acc_q[W-2:0], 1'b1}
                         : {div_sh[W-1:0], acc_q[W-2:0], 1'b0};
    end

    always_comb begin
        prod_s = (s1_q ^ s2_q) ? -acc_q : acc_q;
        q_s    = (s1_q ^ s2_q) ? -acc_q[W-1:0] : acc_q[W-1:0];
        r_s    = s1_q ? -acc_q[2*W-1:W] : acc_q[2*W-1:W];
        if (fast_q)
            sel = acc_q[W-1:0];
        else if (op_q == 3'b000)
            sel = prod_s[W-1:0];
        else if (!op_q[2])
            sel = prod_s[2*W-1:W];
        else if (!op_q[1])
            sel = q_s;
        else
            sel = r_s;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (start) state_nx = fast ? DONE : CALC;
            CALC:    if (cnt_q == '0) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (kill) state_nx = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q   <= '0;
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            fast_q <= 1'b0;
            b_q    <= '0;
            acc_q  <= '0;
            cnt_q  <= '0;
            result <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                op_q   <= MDctrl;
                s1_q   <= neg1;
                s2_q   <= neg2;
                fast_q <= fast;
                cnt_q  <= CW'(W - 1);
                b_q    <= is_div ? m2 : m1;
                if (fast)
                    acc_q <= {{W{1'b0}}, fast_val};
                else
                    acc_q <= {{W{1'b0}}, is_div ? m1 : m2};
            end
            if (state == CALC && !kill) begin
                acc_q <= op_q[2] ? div_nx : mul_nx;
                if (cnt_q != '0) cnt_q <= cnt_q - CW'(1);
            end
            if (state == DONE && !kill) begin
                result <= sel;
                done   <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit at widths 32 and 8: directed vectors plus
// random ops scored against a wide-integer arithmetic model.
module tb_muldiv_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        start32, kill32, start8, kill8;
    logic [2:0]  f32, f8;
    logic [31:0] a32, b32, res32;
    logic [7:0]  a8, b8, res8;
    logic        busy32, done32, busy8, done8;

    int          n_chk = 0;
    int          n_pass = 0;
    logic [31:0] q32[$];
    logic [7:0]  q8[$];
    logic [31:0] last32;

    always #5 clk = ~clk;

    muldiv_unit #(.DATA_WIDTH(32)) u32 (
        .clk(clk), .rst(rst), .start(start32), .kill(kill32),
        .op1(a32), .op2(b32), .MDctrl(f32),
        .busy(busy32), .done(done32), .result(res32)
    );

    muldiv_unit #(.DATA_WIDTH(8)) u8 (
        .clk(clk), .rst(rst), .start(start8), .kill(kill8),
        .op1(a8), .op2(b8), .MDctrl(f8),
        .busy(busy8), .done(done8), .result(res8)
    );

    function automatic logic [31:0] ref_op(input logic [2:0] f,
                                           input logic [31:0] a,
                                           input logic [31:0] b,
                                           input int w);
        logic signed [127:0] m, ua, ub, sa, sb, r;
        m  = (128'sd1 <<< w) - 128'sd1;
        ua = {96'b0, a} & m;
        ub = {96'b0, b} & m;
        sa = ua[w-1] ? ua - (128'sd1 <<< w) : ua;
        sb = ub[w-1] ? ub - (128'sd1 <<< w) : ub;
        case (f)
            3'd0: r = sa * sb;
            3'd1: r = (sa * sb) >>> w;
            3'd2: r = (sa * ub) >>> w;
            3'd3: r = (ua * ub) >>> w;
            3'd4: r = (ub == 0) ? m  : sa / sb;
            3'd5: r = (ub == 0) ? m  : ua / ub;
            3'd6: r = (ub == 0) ? sa : sa % sb;
            default: r = (ub == 0) ? ua : ua % ub;
        endcase
        return r[31:0] & m[31:0];
    endfunction

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, got, exp);
    endtask

    always @(negedge clk) begin
        if (done32 === 1'b1) begin
            if (q32.size() == 0) begin
                n_chk++;
                $display("FAIL done32_spurious: got done=1, expected 0");
            end else chk("model32", res32, q32.pop_front());
        end
        if (done8 === 1'b1) begin
            if (q8.size() == 0) begin
                n_chk++;
                $display("FAIL done8_spurious: got done=1, expected 0");
            end else chk("model8", {24'b0, res8}, {24'b0, q8.pop_front()});
        end
    end

    task automatic go(input bit n8, input logic [2:0] f,
                      input logic [31:0] a, input logic [31:0] b,
                      input bit push);
        if (n8) begin
            start8 = 1'b1; f8 = f; a8 = a[7:0]; b8 = b[7:0];
            if (push) q8.push_back(ref_op(f, a, b, 8));
        end else begin
            start32 = 1'b1; f32 = f; a32 = a; b32 = b;
            if (push) begin
                q32.push_back(ref_op(f, a, b, 32));
                last32 = ref_op(f, a, b, 32);
            end
        end
        @(posedge clk); #1;
        start32 = 1'b0; start8 = 1'b0;
        f32 = 3'($urandom); a32 = $urandom; b32 = $urandom;
        f8 = 3'($urandom); a8 = 8'($urandom); b8 = 8'($urandom);
    endtask

    task automatic waitd(input bit n8, input int exp_lat,
                         input string name, input int inj_at);
        int lat = 1;
        while (1) begin
            if (lat == inj_at && !n8) begin
                start32 = 1'b1; f32 = 3'b100;
                a32 = 32'd100; b32 = 32'd3;
            end else begin
                start32 = 1'b0; start8 = 1'b0;
            end
            @(negedge clk);
            if ((n8 ? done8 : done32) === 1'b1) break;
            if (lat >= 200) break;
            @(posedge clk); #1;
            lat++;
        end
        start32 = 1'b0; start8 = 1'b0;
        chk({name, "_lat"}, lat, exp_lat);
    endtask

    task automatic run(input bit n8, input logic [2:0] f,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int lat,
                       input string name, input int inj_at);
        go(n8, f, a, b, 1'b1);
        waitd(n8, lat, name, inj_at);
        chk(name, n8 ? {24'b0, res8} : res32, exp);
    endtask

    initial begin
        #5000000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        logic [2:0]  f;
        logic [31:0] a, b;
        int          lat;
        rst = 1'b1; start32 = 1'b0; kill32 = 1'b0;
        start8 = 1'b0; kill8 = 1'b0;
        f32 = '0; a32 = '0; b32 = '0; f8 = '0; a8 = '0; b8 = '0;
        last32 = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", {31'b0, busy32}, 32'd0);
        chk("rst_done", {31'b0, done32}, 32'd0);
        chk("rst_result", res32, 32'd0);
        chk("rst_result8", {24'b0, res8}, 32'd0);

        chk("pin_mul", ref_op(3'd0, 32'd7, 32'hFFFFFFFD, 32), 32'hFFFFFFEB);
        chk("pin_mulhsu", ref_op(3'd2, '1, '1, 32), 32'hFFFFFFFF);
        chk("pin_rem", ref_op(3'd6, 32'hFFFFFFF9, 32'd2, 32), 32'hFFFFFFFF);
        chk("pin_div8", ref_op(3'd4, 32'h80, 32'hFF, 8), 32'h80);

        run(0, 3'd0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 34, "mul", 0);
        run(0, 3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 34, "mulh", 0);
        run(0, 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 34, "mulhsu", 0);
        run(0, 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34, "mulhu", 0);
        run(0, 3'd4, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 34, "div", 0);
        run(0, 3'd6, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 34, "rem", 0);
        run(0, 3'd5, 32'hFFFFFFF9, 32'd2, 32'h7FFFFFFC, 34, "divu", 0);
        run(0, 3'd7, 32'd100, 32'd7, 32'd2, 34, "remu", 0);
        run(0, 3'd5, 32'd5, 32'd0, 32'hFFFFFFFF, 2, "divu0", 0);
        run(0, 3'd7, 32'd5, 32'd0, 32'd5, 2, "remu0", 0);
        run(0, 3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 2, "div_ovf", 0);
        run(0, 3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0, 2, "rem_ovf", 0);
        run(0, 3'd6, 32'hFFFFFFFD, 32'd0, 32'hFFFFFFFD, 2, "rem0", 0);
        run(0, 3'd0, 32'h12345, 32'h1000, 32'h12345000, 34, "mul_ign", 5);
        run(0, 3'd3, 32'hFFFFFFFF, 32'd2, 32'd1, 34, "b2b", 0);

        go(0, 3'd4, 32'd1000, 32'd7, 1'b0);
        repeat (9) @(posedge clk);
        #1 kill32 = 1'b1;
        @(posedge clk); #1 kill32 = 1'b0;
        @(negedge clk);
        chk("kill_busy", {31'b0, busy32}, 32'd0);
        repeat (40) @(negedge clk);
        chk("kill_result", res32, last32);

        go(0, 3'd0, 32'd5, 32'd6, 1'b0);
        repeat (9) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        last32 = '0;
        @(negedge clk);
        chk("rstmid_busy", {31'b0, busy32}, 32'd0);
        chk("rstmid_done", {31'b0, done32}, 32'd0);
        chk("rstmid_result", res32, last32);
        repeat (40) @(negedge clk);

        start32 = 1'b1; kill32 = 1'b1;
        f32 = 3'd0; a32 = 32'd3; b32 = 32'd3;
        @(posedge clk); #1 start32 = 1'b0; kill32 = 1'b0;
        @(negedge clk);
        chk("killstart_busy", {31'b0, busy32}, 32'd0);
        repeat (40) @(negedge clk);
        chk("killstart_result", res32, last32);
        run(0, 3'd0, 32'd3, 32'd3, 32'd9, 34, "mul_after", 0);

        run(1, 3'd3, 32'hFF, 32'hFF, 32'hFE, 10, "mulhu8", 0);
        run(1, 3'd4, 32'h80, 32'hFF, 32'h80, 2, "div8_ovf", 0);
        run(1, 3'd4, 32'h80, 32'h03, 32'hD6, 10, "div8", 0);

        for (int i = 0; i < 3000; i++) begin
            f = 3'($urandom_range(0, 7));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: b[7:0] = 8'h00;
                1: begin b[7:0] = 8'hFF; a[7:0] = 8'h80; end
                2: b[7:0] = 8'h01;
                default: ;
            endcase
            lat = (f[2] && (b[7:0] == 8'h00 || (!f[0]
                   && a[7:0] == 8'h80 && b[7:0] == 8'hFF))) ? 2 : 10;
            go(1, f, a, b, 1'b1);
            waitd(1, lat, "rand8", 0);
        end

        for (int i = 0; i < 300; i++) begin
            f = 3'($urandom_range(0, 7));
            a = $urandom;
            b = ($urandom_range(0, 9) == 0) ? 32'd0 : $urandom;
            lat = (f[2] && b == 32'd0) ? 2 : 34;
            go(0, f, a, b, 1'b1);
            waitd(0, lat, "rand32", 0);
        end

        @(negedge clk);
        chk("q32_drained", q32.size(), 32'd0);
        chk("q8_drained", q8.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
